axi_excl_monitor: RTL

AXI_EXCL_MONITOR -- requirements
Module: axi_excl_monitor

---
 rtl/axi_excl_monitor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/axi_excl_monitor.sv
// AXI exclusive-access monitor: snoops AR/AW handshakes, keeps one reservation per ID
// and reports pass/fail of each exclusive write. Optional counters: AXI_EXCL_MONITOR_STATS_EN.
module axi_excl_monitor #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int GRAN_BITS  = 6
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_WIDTH-1:0]      arid,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic                     arlock,
    input  logic                     awvalid,
    input  logic                     awready,
    input  logic [ID_WIDTH-1:0]      awid,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awlock,
    output logic                     chk_valid,
    output logic [ID_WIDTH-1:0]      chk_id,
    output logic                     chk_exokay,
    output logic                     chk_fail,
    output logic [2**ID_WIDTH-1:0]   resv_valid
`ifdef AXI_EXCL_MONITOR_STATS_EN
    ,
    output logic [15:0]              stat_pass,
    output logic [15:0]              stat_fail
`endif
);

    localparam int NUM_IDS = 2**ID_WIDTH;

    // Tags are kept as the full-width shifted address; the upper GRAN_BITS bits are
    // always zero and get trimmed by synthesis, while every address bit stays consumed.
    typedef logic [ADDR_WIDTH-1:0] tag_t;

    logic [NUM_IDS-1:0] entry_valid;
    tag_t               entry_tag [NUM_IDS];
    logic [NUM_IDS-1:0] entry_valid_next;
    tag_t               entry_tag_next [NUM_IDS];

    logic ar_hs;
    logic aw_hs;
    tag_t ar_tag;
    tag_t aw_tag;
    logic wr_hit;
    logic excl_pass;
    logic excl_fail;
    logic clear_en;

    assign ar_hs  = arvalid & arready;
    assign aw_hs  = awvalid & awready;
    assign ar_tag = araddr >> GRAN_BITS;
    assign aw_tag = awaddr >> GRAN_BITS;

    assign wr_hit    = entry_valid[awid] && (entry_tag[awid] == aw_tag);
    assign excl_pass = aw_hs & awlock & wr_hit;
    assign excl_fail = aw_hs & awlock & ~wr_hit;
    assign clear_en  = aw_hs & (~awlock | wr_hit);

    // Write-side clearing uses pre-cycle state; the AR reservation is applied last so a
    // same-cycle reservation survives a write to its own granule.
    always_comb begin
        entry_valid_next = entry_valid;
        for (int i = 0; i < NUM_IDS; i++) begin
            entry_tag_next[i] = entry_tag[i];
            if (clear_en && entry_valid[i] && (entry_tag[i] == aw_tag)) begin
                entry_valid_next[i] = 1'b0;
            end
        end
        if (ar_hs && arlock) begin
            entry_valid_next[arid] = 1'b1;
            entry_tag_next[arid]   = ar_tag;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            entry_valid <= '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                entry_tag[i] <= '0;
            end
        end else begin
            entry_valid <= entry_valid_next;
            for (int i = 0; i < NUM_IDS; i++) begin
                entry_tag[i] <= entry_tag_next[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chk_valid  <= 1'b0;
            chk_id     <= '0;
            chk_exokay <= 1'b0;
            chk_fail   <= 1'b0;
        end else begin
            chk_valid  <= aw_hs;
            chk_id     <= aw_hs ? awid : '0;
            chk_exokay <= excl_pass;
            chk_fail   <= excl_fail;
        end
    end

    assign resv_valid = entry_valid;

`ifdef AXI_EXCL_MONITOR_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pass <= '0;
            stat_fail <= '0;
        end else begin
            if (excl_pass && (stat_pass != 16'hFFFF)) begin
                stat_pass <= stat_pass + 16'd1;
            end
            if (excl_fail && (stat_fail != 16'hFFFF)) begin
                stat_fail <= stat_fail + 16'd1;
            end
        end
    end
`endif

endmodule
